dsp_slice: RTL and testbench

//  27x27 signed fixed-point DSP slice, a Stratix10-style variable-precision block.

---
 rtl/dsp_slice.sv | 189 ++++++++++++++++++
 tb/tb_dsp_slice.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_slice.sv
// dsp_slice: 27x27 signed variable-precision DSP slice.
// It has an optional Y+Z pre-adder, a 28x27 multiplier, and a 64-bit
// accumulate/chain adder followed by an optional output register.
// Optional feature macro: DSP_COEF_ROM_EN. When defined, coefsela selects
// between ax and a seven-entry coefficient bank (COEF_1..COEF_7).
module dsp_slice #(
  parameter logic signed [26:0] COEF_1 = 27'sd1,
  parameter logic signed [26:0] COEF_2 = 27'sd2,
  parameter logic signed [26:0] COEF_3 = 27'sd3,
  parameter logic signed [26:0] COEF_4 = 27'sd4,
  parameter logic signed [26:0] COEF_5 = 27'sd5,
  parameter logic signed [26:0] COEF_6 = 27'sd6,
  parameter logic signed [26:0] COEF_7 = 27'sd7
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        ena,
  input  logic        loadconst,
  input  logic        accumulate,
  input  logic        negate,
  input  logic [26:0] ay,
  input  logic [25:0] az,
  input  logic [26:0] ax,
  input  logic [2:0]  coefsela,
  input  logic [26:0] scanin,
  input  logic [63:0] chainin,
  output logic [26:0] scanout,
  output logic [63:0] chainout,
  output logic [63:0] resulta,
  input  logic [4:0]  mux_sel,
  input  logic [63:0] constant
);

  localparam int unsigned XW = 27;
  localparam int unsigned YW = 27;
  localparam int unsigned ZW = 26;
  localparam int unsigned PYW = 28;
  localparam int unsigned PW = 55;
  localparam int unsigned RW = 64;
  localparam int unsigned CW = 3;

  // Static configuration decode
  logic pre_en_c, in_reg_en_c, chain_en_c, out_reg_en_c, scan_sel_c;
  assign pre_en_c     = mux_sel[0];
  assign in_reg_en_c  = mux_sel[1];
  assign chain_en_c   = mux_sel[2];
  assign out_reg_en_c = mux_sel[3];
  assign scan_sel_c   = mux_sel[4];

  // Input stage registers, scan register and accumulator
  logic [XW-1:0] ax_q, ax_d;
  logic [YW-1:0] ay_q, ay_d;
  logic [ZW-1:0] az_q, az_d;
  logic          neg_q, neg_d;
  logic          ldc_q, ldc_d;
  logic          accf_q, accf_d;
  logic [CW-1:0] cs_q, cs_d;
  logic [YW-1:0] scan_q, scan_d;
  logic [RW-1:0] acc_q, acc_d;

  // Datapath nets
  logic [YW-1:0]        ay_sel_c;
  logic [XW-1:0]        ax_eff_c;
  logic [YW-1:0]        ay_eff_c;
  logic [ZW-1:0]        az_eff_c;
  logic                 neg_eff_c, ldc_eff_c, accf_eff_c;
  logic [CW-1:0]        cs_eff_c;
  logic signed [XW-1:0] x_op_c;
  logic signed [PYW-1:0] y_prime_c;
  logic signed [PW-1:0] prod_c;
  logic [RW-1:0]        prod64_c;
  logic [RW-1:0]        sum_c;

  // Y operand source: local ay or the previous slice's scan chain
  assign ay_sel_c = scan_sel_c ? scanin : ay;

  // Operand selection: registered input stage or live bypass
  always_comb begin
    ax_eff_c   = ax;
    ay_eff_c   = ay_sel_c;
    az_eff_c   = az;
    neg_eff_c  = negate;
    ldc_eff_c  = loadconst;
    accf_eff_c = accumulate;
    cs_eff_c   = coefsela;
    if (in_reg_en_c) begin
      ax_eff_c   = ax_q;
      ay_eff_c   = ay_q;
      az_eff_c   = az_q;
      neg_eff_c  = neg_q;
      ldc_eff_c  = ldc_q;
      accf_eff_c = accf_q;
      cs_eff_c   = cs_q;
    end
  end

`ifdef DSP_COEF_ROM_EN
  // X operand: ax when coefsela is 0, otherwise a coefficient bank entry
  always_comb begin
    x_op_c = $signed(ax_eff_c);
    case (cs_eff_c)
      3'd1:    x_op_c = COEF_1;
      3'd2:    x_op_c = COEF_2;
      3'd3:    x_op_c = COEF_3;
      3'd4:    x_op_c = COEF_4;
      3'd5:    x_op_c = COEF_5;
      3'd6:    x_op_c = COEF_6;
      3'd7:    x_op_c = COEF_7;
      default: x_op_c = $signed(ax_eff_c);
    endcase
  end
`else
  // Without the coefficient bank, X is always ax, and coefsela plus the bank
  // parameters are folded into a sink.
  logic unused_coef;
  assign unused_coef = ^{cs_eff_c, COEF_1, COEF_2, COEF_3, COEF_4,
                         COEF_5, COEF_6, COEF_7};
  assign x_op_c = $signed(ax_eff_c);
`endif

  // Pre-adder, multiplier and the 64-bit sum
  always_comb begin
    y_prime_c = $signed({ay_eff_c[YW-1], ay_eff_c});
    if (pre_en_c) begin
      y_prime_c = y_prime_c + $signed({{(PYW-ZW){az_eff_c[ZW-1]}}, az_eff_c});
    end
    prod_c   = PW'(y_prime_c) * PW'(x_op_c);
    prod64_c = {{(RW-PW){prod_c[PW-1]}}, prod_c};
    sum_c    = neg_eff_c ? (RW'(0) - prod64_c) : prod64_c;
    if (accf_eff_c) sum_c = sum_c + acc_q;
    if (ldc_eff_c)  sum_c = sum_c + constant;
    if (chain_en_c) sum_c = sum_c + chainin;
  end

  // Next-state for all registers; ena=0 holds everything
  always_comb begin
    ax_d   = ax_q;
    ay_d   = ay_q;
    az_d   = az_q;
    neg_d  = neg_q;
    ldc_d  = ldc_q;
    accf_d = accf_q;
    cs_d   = cs_q;
    scan_d = scan_q;
    acc_d  = acc_q;
    if (ena) begin
      ax_d   = ax;
      ay_d   = ay_sel_c;
      az_d   = az;
      neg_d  = negate;
      ldc_d  = loadconst;
      accf_d = accumulate;
      cs_d   = coefsela;
      scan_d = ay_sel_c;
      acc_d  = sum_c;
    end
  end

  // Register bank with asynchronous active-low clear
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ax_q   <= '0;
      ay_q   <= '0;
      az_q   <= '0;
      neg_q  <= 1'b0;
      ldc_q  <= 1'b0;
      accf_q <= 1'b0;
      cs_q   <= '0;
      scan_q <= '0;
      acc_q  <= '0;
    end else begin
      ax_q   <= ax_d;
      ay_q   <= ay_d;
      az_q   <= az_d;
      neg_q  <= neg_d;
      ldc_q  <= ldc_d;
      accf_q <= accf_d;
      cs_q   <= cs_d;
      scan_q <= scan_d;
      acc_q  <= acc_d;
    end
  end

  // Output selection: accumulator register or combinational sum
  assign resulta  = out_reg_en_c ? acc_q : sum_c;
  assign chainout = resulta;
  assign scanout  = scan_q;

endmodule

// File: tb/tb_dsp_slice.sv
// Self-checking bench for dsp_slice. It uses a transaction-level reference
// model with plain integer arithmetic.
module tb_dsp_slice;

  logic        clk = 1'b0;
  logic        clr;
  logic        ena;
  logic        loadconst, accumulate, negate;
  logic [26:0] ay, ax, scanin;
  logic [25:0] az;
  logic [2:0]  coefsela;
  logic [63:0] chainin, constant;
  logic [4:0]  mux_sel;
  logic [26:0] scanout;
  logic [63:0] chainout, resulta;

  int checks = 0;
  int failures = 0;

  dsp_slice dut (
    .clk(clk), .clr(clr), .ena(ena), .loadconst(loadconst),
    .accumulate(accumulate), .negate(negate), .ay(ay), .az(az), .ax(ax),
    .coefsela(coefsela), .scanin(scanin), .chainin(chainin),
    .scanout(scanout), .chainout(chainout), .resulta(resulta),
    .mux_sel(mux_sel), .constant(constant)
  );

  always #5 clk = ~clk;

  // One operand set as the slice sees it
  typedef struct {
    logic [26:0] ax;
    logic [26:0] ays;
    logic [25:0] az;
    logic        neg;
    logic        ldc;
    logic        accf;
    logic [2:0]  cs;
  } op_t;

  op_t         m_stage;
  logic [63:0] m_acc;
  logic [26:0] m_scan;

  function automatic op_t cur_op();
    op_t o;
    o.ax   = ax;
    o.ays  = mux_sel[4] ? scanin : ay;
    o.az   = az;
    o.neg  = negate;
    o.ldc  = loadconst;
    o.accf = accumulate;
    o.cs   = coefsela;
    return o;
  endfunction

  function automatic op_t zero_op();
    op_t o;
    o.ax = '0; o.ays = '0; o.az = '0;
    o.neg = 1'b0; o.ldc = 1'b0; o.accf = 1'b0; o.cs = '0;
    return o;
  endfunction

  // Sum from the arithmetic rules: (+/-)Y'*X + acc + constant + chainin, mod 2^64
  function automatic logic [63:0] msum(op_t o);
    longint y, x, p, s;
    y = longint'($signed(o.ays));
    if (mux_sel[0]) y = y + longint'($signed(o.az));
    x = longint'($signed(o.ax));
`ifdef DSP_COEF_ROM_EN
    if (o.cs != 3'd0) x = longint'(o.cs);
`endif
    p = y * x;
    s = o.neg ? -p : p;
    if (o.accf) s = s + longint'(m_acc);
    if (o.ldc) s = s + longint'(constant);
    if (mux_sel[2]) s = s + longint'(chainin);
    return 64'(s);
  endfunction

  function automatic logic [63:0] exp_result();
    op_t e;
    e = mux_sel[1] ? m_stage : cur_op();
    return mux_sel[3] ? m_acc : msum(e);
  endfunction

  task automatic model_reset();
    m_stage = zero_op();
    m_acc   = '0;
    m_scan  = '0;
  endtask

  task automatic check_outs(input string tag);
    logic [63:0] er;
    er = exp_result();
    checks++;
    if (resulta !== er) begin
      failures++;
      $display("FAIL %s resulta got=%h exp=%h", tag, resulta, er);
    end
    checks++;
    if (chainout !== er) begin
      failures++;
      $display("FAIL %s chainout got=%h exp=%h", tag, chainout, er);
    end
    checks++;
    if (scanout !== m_scan) begin
      failures++;
      $display("FAIL %s scanout got=%h exp=%h", tag, scanout, m_scan);
    end
  endtask

  // Advance one clock: the model commits its next state, then we move to the next negedge
  task automatic tick();
    op_t e, c;
    if (clr && ena) begin
      c = cur_op();
      e = mux_sel[1] ? m_stage : c;
      m_acc   = msum(e);
      m_stage = c;
      m_scan  = c.ays;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_std(input logic [4:0] ms);
    ax = 27'd1; ay = 27'd2; az = 26'd3; chainin = 64'd1; constant = 64'd2;
    scanin = '0; coefsela = '0; ena = 1'b1;
    loadconst = 1'b0; accumulate = 1'b0; negate = 1'b0;
    mux_sel = ms;
  endtask

  task automatic pulse_reset();
    clr = 1'b0;
    model_reset();
    #1;
    check_outs("reset_pulse");
    clr = 1'b1;
    #1;
  endtask

  task automatic expect_res(input string tag, input logic [63:0] v);
    checks++;
    if (resulta !== v) begin
      failures++;
      $display("FAIL %s resulta got=%h exp=%h", tag, resulta, v);
    end
  endtask

  task automatic test_reset();
    set_std(5'b01111);
    clr = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    expect_res("reset_res", 64'd0);
    check_outs("reset");
    clr = 1'b1;
  endtask

  task automatic test_preadd_pipe();
    pulse_reset();
    set_std(5'b01111);
    #1; check_outs("t1_e0");
    tick(); #1; check_outs("t1_e1");
    tick(); #1; check_outs("t1_e2");
    expect_res("t1_value", 64'd6);
  endtask

  task automatic test_accumulate();
    accumulate = 1'b1;
    tick(); #1; expect_res("t3_acc1", 64'd6);  check_outs("t3_1");
    tick(); #1; expect_res("t3_acc2", 64'd12); check_outs("t3_2");
    tick(); #1; expect_res("t3_acc3", 64'd18); check_outs("t3_3");
  endtask

  task automatic test_loadconst();
    pulse_reset();
    set_std(5'b01111);
    loadconst = 1'b1;
    tick(); tick(); #1;
    expect_res("t2_ldc", 64'd8);
    check_outs("t2_ldc");
    mux_sel = 5'b11111;
    tick(); tick(); #1;
    check_outs("t2_scanin");
  endtask

  task automatic test_negate();
    pulse_reset();
    set_std(5'b01111);
    negate = 1'b1;
    tick(); tick(); #1;
    expect_res("t4_neg", 64'hFFFF_FFFF_FFFF_FFFC);
    check_outs("t4_neg");
  endtask

  task automatic test_reset_mid_acc();
    pulse_reset();
    set_std(5'b01111);
    accumulate = 1'b1;
    tick(); tick(); tick(); #1;
    check_outs("t5_pre");
    clr = 1'b0;
    model_reset();
    #1;
    expect_res("t5_clr_res", 64'd0);
    check_outs("t5_clr");
    clr = 1'b1;
    #1;
    tick(); #1; check_outs("t5_post1");
    tick(); #1; check_outs("t5_post2");
  endtask

  task automatic test_ena_hold();
    set_std(5'b01111);
    accumulate = 1'b1;
    tick(); #1;
    ena = 1'b0;
    ax = 27'd9; ay = 27'd7;
    tick(); #1; check_outs("ena_hold1");
    tick(); #1; check_outs("ena_hold2");
    ena = 1'b1;
    tick(); #1; check_outs("ena_resume");
  endtask

  task automatic test_comb_path();
    set_std(5'b00101);
    #1; check_outs("comb0");
    ax = 27'h7FF_FFFF; ay = 27'h400_0000; az = 26'h200_0000;
    #1; check_outs("comb_neg_extremes");
    negate = 1'b1; loadconst = 1'b1;
    #1; check_outs("comb_neg_ldc");
    tick(); #1; check_outs("comb_after_edge");
  endtask

`ifdef DSP_COEF_ROM_EN
  task automatic test_coef();
    pulse_reset();
    set_std(5'b01111);
    coefsela = 3'd3;
    tick(); tick(); #1;
    expect_res("t6_coef", 64'd16);
    check_outs("t6_coef");
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i % 16 == 0) mux_sel = 5'($urandom);
      ax        = 27'($urandom);
      ay        = 27'($urandom);
      az        = 26'($urandom);
      scanin    = 27'($urandom);
      chainin   = {32'($urandom), 32'($urandom)};
      constant  = {32'($urandom), 32'($urandom)};
      coefsela  = 3'($urandom);
      negate    = 1'($urandom);
      loadconst = 1'($urandom);
      accumulate = ($urandom % 4) != 0;
      ena       = ($urandom % 5) != 0;
      if ($urandom % 40 == 0) pulse_reset();
      #1;
      check_outs($sformatf("rand_%0d", i));
      tick();
    end
  endtask

  initial begin
    clr = 1'b0;
    set_std(5'b01111);
    model_reset();
    @(negedge clk);
    test_reset();
    test_preadd_pipe();
    test_accumulate();
    test_loadconst();
    test_negate();
    test_reset_mid_acc();
    test_ena_hold();
    test_comb_path();
`ifdef DSP_COEF_ROM_EN
    test_coef();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
